traffic_density_classifier: RTL
===============================

Name: traffic_density_classifier

Overview:
- Upstream stage of the traffic-light control unit: converts per-pixel vehicle detections from the VGA image-processing pipeline into the one-bit flow-state select `traffic_sel` (0 = normal flow, 1 = heavy flow) that drives the signal FSM.
- Counts vehicle pixels per frame and compares the total against two thresholds with hysteresis.
- A change of state is committed only after CONFIRM_FRAMES consecutive qualifying frames, so the signal controller never sees a flickering select.

Parameters:
- CNT_W, 17, width of the per-frame pixel counter (320x240 = 76800 fits).
- HIGH_TH, 20000, frame count >= HIGH_TH qualifies as heavy.
- LOW_TH, 12000, frame count < LOW_TH qualifies as normal; must satisfy LOW_TH < HIGH_TH.
- CONFIRM_FRAMES, 4, consecutive qualifying frames needed to switch state (range 1..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- frame_start  input  1  one-cycle pulse on the first active pixel of each frame.
- pix_valid  input  1  active-video pixel strobe.
- obj_pix  input  1  pixel classified as vehicle; only meaningful when pix_valid=1.
- traffic_sel  output  1  committed flow state; connects to the control unit's traffic_sel input.
- sel_valid  output  1  one-cycle pulse when traffic_sel changes value.
- frame_cnt  output  CNT_W  vehicle-pixel count of the last completed frame.
- frame_done  output  1  one-cycle pulse when frame_cnt updates.

Behaviour:
- Reset, asynchronous, applies immediately regardless of clk and may assert mid-frame:
  - traffic_sel=0, sel_valid=0, frame_cnt=0, frame_done=0.
  - Accumulator=0, streak counter=0, FSM to WAIT_FRAME.
  - The partial frame is discarded.
- FSM states:
  - WAIT_FRAME: after reset, nothing counted. On frame_start, go to ACCUM; the accumulator loads (pix_valid&obj_pix) from that same cycle. No evaluation occurs for this first (incomplete) frame.
  - ACCUM: the accumulator increments by 1 on every cycle with pix_valid&obj_pix. It saturates at 2^CNT_W-1 (no wrap). On frame_start, go to EVAL: latch accumulator into frame_cnt, pulse frame_done, and reload the accumulator with that cycle's (pix_valid&obj_pix). The frame_start pixel always belongs to the new frame.
  - EVAL: single cycle. Counting continues normally in parallel. Apply the decision rules below, then return to ACCUM. A frame_start arriving in EVAL, which implies a 1-cycle frame, is treated exactly as in ACCUM: latch, pulse, and re-enter EVAL.
- Timing (frame_start at cycle T):
  - frame_cnt and frame_done valid at T+1.
  - traffic_sel and sel_valid updated at T+2.
- Decision rules in EVAL, with C = frame_cnt:
  - traffic_sel=0 and C >= HIGH_TH: streak++.
  - traffic_sel=1 and C < LOW_TH: streak++.
  - Any other C (including the hysteresis band LOW_TH <= C < HIGH_TH): streak=0.
  - When streak reaches CONFIRM_FRAMES: toggle traffic_sel, pulse sel_valid, and reset streak to 0.
- sel_valid never asserts without a traffic_sel change. traffic_sel is held stable between changes.
- Streak is 4 bits and never exceeds CONFIRM_FRAMES.
- Comparisons are unsigned at CNT_W width.

Optional Feature:
- Macro: TDC_ROI_EN.
- When defined:
  - Add inputs pix_x [9:0] and pix_y [9:0].
  - Add parameters ROI_X0=0, ROI_X1=319, ROI_Y0=120, ROI_Y1=239.
  - A pixel counts only if pix_valid&obj_pix and ROI_X0<=pix_x<=ROI_X1 and ROI_Y0<=pix_y<=ROI_Y1 (inclusive bounds). The qualification is combinational, so no added latency.
- When not defined: no coordinate ports; every valid object pixel counts.

Test Plan:
- Reset, then frame_start, then 25000 obj pixels, repeated over 5 frames -> frame_cnt=25000 at T+1 of each later frame_start. traffic_sel rises with a single sel_valid pulse at T+2 of the 4th evaluated frame, and no further pulses.
- traffic_sel=1, then frames of 15000, 11000, 11000, 15000, then 4x11000 -> no switch during the first sequence (streak cleared by the in-band frame). traffic_sel falls after the 4th consecutive 11000 frame.
- Frame with all 76800 pixels valid and obj_pix=1 using CNT_W=16 -> frame_cnt=65535 (saturated, no wrap).
- Assert reset mid-ACCUM after 3 qualifying heavy frames -> all outputs 0 immediately. The next frame_start is not evaluated, and 4 fresh heavy frames are needed to switch.
- frame_start coincident with pix_valid&obj_pix=1, then 9 more hits -> the next frame_cnt=10, and the previous frame's count excludes the boundary pixel.
- With TDC_ROI_EN: 100 hits at pix_y=50 and 100 hits at pix_y=200 -> frame_cnt=100; boundary hits at pix_y=120 and pix_y=239 are counted.

Source files
------------

// File: rtl/traffic_density_classifier.sv
`timescale 1ns/1ps
// traffic_density_classifier
// Counts vehicle pixels per video frame and turns the per-frame total into a
// debounced one-bit flow-state select (0 = normal, 1 = heavy). Thresholds use
// hysteresis, and a new state is committed only after CONFIRM_FRAMES
// consecutive qualifying frames.
// Optional build macro: TDC_ROI_EN adds pix_x/pix_y inputs and restricts
// counting to a rectangular region of interest.
module traffic_density_classifier #(
   parameter int unsigned CNT_W          = 17,
   parameter int unsigned HIGH_TH        = 20000,
   parameter int unsigned LOW_TH         = 12000,
   parameter int unsigned CONFIRM_FRAMES = 4
`ifdef TDC_ROI_EN
   ,
   parameter int unsigned ROI_X0 = 0,
   parameter int unsigned ROI_X1 = 319,
   parameter int unsigned ROI_Y0 = 120,
   parameter int unsigned ROI_Y1 = 239
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_start,
   input  logic             pix_valid,
   input  logic             obj_pix,
`ifdef TDC_ROI_EN
   input  logic [9:0]       pix_x,
   input  logic [9:0]       pix_y,
`endif
   output logic             traffic_sel,
   output logic             sel_valid,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             frame_done
);

   localparam logic [1:0] WAIT_FRAME = 2'd0;
   localparam logic [1:0] ACCUM      = 2'd1;
   localparam logic [1:0] EVAL       = 2'd2;

   localparam logic [CNT_W-1:0] HIGH_C    = CNT_W'(HIGH_TH);
   localparam logic [CNT_W-1:0] LOW_C     = CNT_W'(LOW_TH);
   localparam logic [3:0]       CONFIRM_C = 4'(CONFIRM_FRAMES);

   logic [1:0]       state;
   logic [CNT_W-1:0] acc;
   logic [3:0]       streak;
   logic [3:0]       streak_nxt;
   logic             hit;
   logic             qualify;

   // Pixel qualification: valid vehicle pixel, optionally inside the ROI
`ifdef TDC_ROI_EN
   always_comb begin
      hit = pix_valid & obj_pix
          & (pix_x >= 10'(ROI_X0)) & (pix_x <= 10'(ROI_X1))
          & (pix_y >= 10'(ROI_Y0)) & (pix_y <= 10'(ROI_Y1));
   end
`else
   always_comb begin
      hit = pix_valid & obj_pix;
   end
`endif

   // Frame qualifies when it argues for leaving the current state
   always_comb begin
      qualify    = traffic_sel ? (frame_cnt < LOW_C) : (frame_cnt >= HIGH_C);
      streak_nxt = streak + 4'd1;
   end

   // Frame sequencing and saturating pixel accumulator
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= WAIT_FRAME;
         acc        <= '0;
         frame_cnt  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            WAIT_FRAME: begin
               if (frame_start) begin
                  state <= ACCUM;
                  acc   <= CNT_W'(hit);
               end
            end
            ACCUM, EVAL: begin
               if (frame_start) begin
                  // the frame_start pixel belongs to the new frame
                  state      <= EVAL;
                  frame_cnt  <= acc;
                  frame_done <= 1'b1;
                  acc        <= CNT_W'(hit);
               end else begin
                  state <= ACCUM;
                  if (hit && (acc != '1)) begin
                     acc <= acc + CNT_W'(1);
                  end
               end
            end
            default: state <= WAIT_FRAME;
         endcase
      end
   end

   // Hysteresis decision with consecutive-frame confirmation
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         traffic_sel <= 1'b0;
         sel_valid   <= 1'b0;
         streak      <= '0;
      end else begin
         sel_valid <= 1'b0;
         if (state == EVAL) begin
            if (qualify) begin
               if (streak_nxt >= CONFIRM_C) begin
                  traffic_sel <= ~traffic_sel;
                  sel_valid   <= 1'b1;
                  streak      <= '0;
               end else begin
                  streak <= streak_nxt;
               end
            end else begin
               streak <= '0;
            end
         end
      end
   end

endmodule
